// File: rtl/type_width_sequencer.sv
// rtl/type_width_sequencer.sv - walks nine integral types through a width probe and tallies pass/fail
module type_width_sequencer #(
    parameter int TMO = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       req_vld,
    input  logic       req_rdy,
    output logic [3:0] req_idx,
    input  logic       rsp_vld,
    input  logic [6:0] rsp_width,
    output logic [3:0] pass_cnt,
    output logic [3:0] fail_cnt,
    output logic [3:0] first_fail,
    output logic       err_tmo
);
    localparam logic [3:0] LAST_IDX = 4'd8;
    localparam logic [3:0] NO_FAIL  = 4'hF;
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [3:0] r_idx;
    logic       r_busy;
    logic       r_done;
    logic       r_req_vld;
    logic [3:0] r_pass;
    logic [3:0] r_fail;
    logic [3:0] r_first;
    logic       r_err;

    logic [6:0] w_exp_width;
    logic       w_tmo;
    logic       w_match;

    // Language-defined widths of reg, logic, bit, byte, shortint, int, longint, integer, time
    always_comb begin
        w_exp_width = 7'd1;
        case (r_idx)
            4'd3:    w_exp_width = 7'd8;
            4'd4:    w_exp_width = 7'd16;
            4'd5:    w_exp_width = 7'd32;
            4'd6:    w_exp_width = 7'd64;
            4'd7:    w_exp_width = 7'd32;
            4'd8:    w_exp_width = 7'd64;
            default: w_exp_width = 7'd1;
        endcase
    end

    assign w_tmo   = (r_cnt == TMO_LAST);
    assign w_match = (rsp_width == w_exp_width);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_idx     <= 4'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_req_vld <= 1'b0;
            r_pass    <= 4'd0;
            r_fail    <= 4'd0;
            r_first   <= NO_FAIL;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_ISSUE;
                        r_busy    <= 1'b1;
                        r_req_vld <= 1'b1;
                        r_idx     <= 4'd0;
                        r_pass    <= 4'd0;
                        r_fail    <= 4'd0;
                        r_first   <= NO_FAIL;
                        r_err     <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (req_rdy) begin
                        r_state   <= S_WAIT;
                        r_req_vld <= 1'b0;
                        r_cnt     <= 8'd0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    // A response in the timeout cycle takes priority over the timeout
                    if (rsp_vld || w_tmo) begin
                        if (rsp_vld && w_match) begin
                            r_pass <= r_pass + 4'd1;
                        end else begin
                            r_fail <= r_fail + 4'd1;
                            if (r_first == NO_FAIL) begin
                                r_first <= r_idx;
                            end
                        end
                        if (!rsp_vld) begin
                            r_err <= 1'b1;
                        end
                        if (r_idx == LAST_IDX) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= S_ISSUE;
                            r_idx     <= r_idx + 4'd1;
                            r_req_vld <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign req_vld    = r_req_vld;
    assign req_idx    = r_idx;
    assign pass_cnt   = r_pass;
    assign fail_cnt   = r_fail;
    assign first_fail = r_first;
    assign err_tmo    = r_err;

endmodule

// File: tb/tb_type_width_sequencer.sv
// tb/tb_type_width_sequencer.sv - directed and randomized runs of type_width_sequencer against a table model
module tb_type_width_sequencer;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       req_vld;
    logic       req_rdy;
    logic [3:0] req_idx;
    logic       rsp_vld;
    logic [6:0] rsp_width;
    logic [3:0] pass_cnt;
    logic [3:0] fail_cnt;
    logic [3:0] first_fail;
    logic       err_tmo;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] ref_w [9] = '{7'd1, 7'd1, 7'd1, 7'd8, 7'd16, 7'd32, 7'd64, 7'd32, 7'd64};
    int         rdy_del [9];
    int         rsp_del [9];
    logic [6:0] rsp_w [9];
    bit         spur_en;
    bit         restart_en;

    always #5 clk = ~clk;

    type_width_sequencer #(.TMO(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_idx(req_idx),
        .rsp_vld(rsp_vld), .rsp_width(rsp_width),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail(first_fail), .err_tmo(err_tmo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_req_vld", req_vld, 0);
        check("rst_req_idx", req_idx, 0);
        check("rst_pass", pass_cnt, 0);
        check("rst_fail", fail_cnt, 0);
        check("rst_first_fail", first_fail, 4'hF);
        check("rst_err_tmo", err_tmo, 0);
    endtask

    task automatic set_ideal();
        for (int i = 0; i < 9; i++) begin
            rdy_del[i] = 0;
            rsp_del[i] = 0;
            rsp_w[i]   = ref_w[i];
        end
        spur_en    = 1'b0;
        restart_en = 1'b0;
    endtask

    task automatic set_random();
        for (int i = 0; i < 9; i++) begin
            int r;
            rdy_del[i] = $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            if (r < 7)       rsp_del[i] = $urandom_range(0, 4);
            else if (r == 7) rsp_del[i] = TMO - 1;
            else             rsp_del[i] = TMO + 5;
            if ($urandom_range(0, 3) == 0) rsp_w[i] = ref_w[i] ^ 7'($urandom_range(1, 127));
            else                           rsp_w[i] = ref_w[i];
        end
        spur_en    = 1'($urandom_range(0, 1));
        restart_en = 1'($urandom_range(0, 1));
    endtask

    // Expected tallies and done cycle (counted from the first cycle after start) from the probe plan
    task automatic model(output int p, output int f, output int ff, output bit e, output int dn);
        p = 0; f = 0; ff = 15; e = 1'b0; dn = 1;
        for (int i = 0; i < 9; i++) begin
            bit answered;
            answered = (rsp_del[i] < TMO);
            if (answered && rsp_w[i] == ref_w[i]) begin
                p++;
            end else begin
                f++;
                if (ff == 15) ff = i;
                if (!answered) e = 1'b1;
            end
            dn += rdy_del[i] + 1 + (answered ? rsp_del[i] + 1 : TMO);
        end
    endtask

    task automatic run_case(input int abort_idx);
        int cyc, issue_cnt, w, k, e_p, e_f, e_ff, e_dn;
        bit e_e, in_wait, finished;
        model(e_p, e_f, e_ff, e_e, e_dn);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; k = 0; issue_cnt = 0; w = 0; in_wait = 1'b0; finished = 1'b0;
        check("busy_after_start", busy, 1);
        check("req_vld_after_start", req_vld, 1);
        while (!finished && cyc < 2000) begin
            req_rdy   = 1'b0;
            rsp_vld   = 1'b0;
            rsp_width = 7'($urandom);
            start     = restart_en && ($urandom_range(0, 3) == 0);
            if (in_wait) begin
                check("req_vld_low_in_wait", req_vld, 0);
                if (k == abort_idx) begin
                    rst = 1'b1; start = 1'b0; rsp_vld = 1'b1; rsp_width = ref_w[k];
                    @(negedge clk);
                    rst = 1'b0;
                    check_reset_vals();
                    repeat (2) begin
                        @(negedge clk);
                        check("late_rsp_pass", pass_cnt, 0);
                        check("late_rsp_busy", busy, 0);
                    end
                    rsp_vld = 1'b0;
                    return;
                end
                rsp_vld = (w == rsp_del[k]);
                if (rsp_vld) rsp_width = rsp_w[k];
                if (rsp_vld || w == TMO - 1) begin
                    in_wait = 1'b0; k++; issue_cnt = 0;
                end
                w++;
            end else if (done) begin
                start = 1'b0;
                check("done_cycle", cyc, e_dn);
                check("done_types", k, 9);
                finished = 1'b1;
            end else if (req_vld) begin
                check("req_idx", req_idx, k);
                if (issue_cnt >= rdy_del[k]) begin
                    req_rdy = 1'b1; in_wait = 1'b1; w = 0;
                end else if (spur_en) begin
                    rsp_vld = 1'b1; rsp_width = rsp_w[k] ^ 7'd3;
                end
                issue_cnt++;
            end
            @(negedge clk);
            cyc++;
        end
        check("run_completed", finished, 1);
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
        check("pass_cnt", pass_cnt, e_p);
        check("fail_cnt", fail_cnt, e_f);
        check("first_fail", first_fail, e_ff);
        check("err_tmo", err_tmo, e_e);
        rsp_vld = 1'b1; rsp_width = ref_w[0];
        @(negedge clk);
        rsp_vld = 1'b0;
        check("hold_pass_cnt", pass_cnt, e_p);
        check("hold_fail_cnt", fail_cnt, e_f);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; req_rdy = 1'b0; rsp_vld = 1'b0; rsp_width = 7'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_vals();
        rsp_vld = 1'b1; rsp_width = 7'd1;
        @(negedge clk);
        rsp_vld = 1'b0;
        check("idle_rsp_pass", pass_cnt, 0);
        check("idle_rsp_busy", busy, 0);

        set_ideal();
        run_case(-1);

        set_ideal();
        rsp_w[7] = 7'd16;
        rsp_w[8] = 7'd32;
        run_case(-1);

        set_ideal();
        rsp_del[4] = TMO + 5;
        run_case(-1);

        set_ideal();
        rdy_del[0] = 5; spur_en = 1'b1; restart_en = 1'b1;
        run_case(-1);

        set_ideal();
        run_case(5);
        set_ideal();
        run_case(-1);

        set_ideal();
        rsp_del[2] = TMO - 1;
        rsp_del[6] = TMO - 1;
        run_case(-1);

        for (int n = 0; n < 8; n++) begin
            set_random();
            run_case(-1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
